// File: rtl/mac_core_p.sv
// mac_core_p: matrix-word x source-operand multiply-accumulate core.
// A small matrix RAM feeds a 3-stage MAC pipeline; an output register
// chains to neighbouring cores so results can be shifted out serially.
module mac_core_p #(
   parameter int DW     = 16,
   parameter int AW     = 7,
   parameter int LW     = 2,
   parameter int ACC_W  = 32,
   parameter int SIGNED = 1,
   parameter int SAT    = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                init,
   input  logic                mat_v,
   input  logic [AW-1:0]       mat_a,
   input  logic [LW*DW-1:0]    mat_d,
   input  logic                exec,
   input  logic [AW-1:0]       exec_mat_addr,
   input  logic [DW-1:0]       exec_src_data,
   input  logic                out_period,
   input  logic                update,
   input  logic [ACC_W-1:0]    acc_next,
   output logic [ACC_W-1:0]    acc,
   output logic                busy,
   output logic                ovf
);

   localparam int DEPTH = 1 << AW;
   localparam bit SGN   = (SIGNED != 0);

   logic [DW-1:0]      r_mem [DEPTH];

   logic [DW-1:0]      r_mat_rd_p1;
   logic               r_vld_p1;
   logic               r_init_p1;

   logic [DW-1:0]      r_m2_p2;
   logic [DW-1:0]      r_d2_p2;
   logic               r_vld_p2;
   logic               r_init_p2;

   logic [ACC_W-1:0]   r_acc_left;
   logic [ACC_W-1:0]   r_acc_right;
   logic               r_ovf;

   logic [2*DW-1:0]    w_m_ext;
   logic [2*DW-1:0]    w_d_ext;
   logic [2*DW-1:0]    w_prod;
   logic [ACC_W-1:0]   w_prod_acc;
   logic [ACC_W:0]     w_sum;
   logic               w_sum_ovf;
   logic [ACC_W-1:0]   w_acc_new;

   // Keep the low ACC_W bits of the extended sum (modular accumulate).
   function automatic logic [ACC_W-1:0] f_wrap(input logic [ACC_W:0] s);
      return s[ACC_W-1:0];
   endfunction

   // Clamp an out-of-range extended sum to the nearest representable bound.
   function automatic logic [ACC_W-1:0] f_saturate(input logic [ACC_W:0] s);
      logic [ACC_W-1:0] r;
      r = s[ACC_W-1:0];
      if (SGN) begin
         if (s[ACC_W] != s[ACC_W-1]) begin
            r = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
         end
      end else if (s[ACC_W]) begin
         r = '1;
      end
      return r;
   endfunction

   // Matrix load: LW consecutive words, address wraps within the RAM.
   always_ff @(posedge clk) begin
      if (!rst && mat_v) begin
         for (int k = 0; k < LW; k++) begin
            r_mem[mat_a + AW'(k)] <= mat_d[k*DW +: DW];
         end
      end
   end

   // Stage p1: registered matrix read and issue tracking for exec/init.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld_p1  <= 1'b0;
         r_init_p1 <= 1'b0;
      end else begin
         r_vld_p1  <= exec;
         r_init_p1 <= init;
         if (exec) begin
            r_mat_rd_p1 <= r_mem[exec_mat_addr];
         end
      end
   end

   // Stage p2: operand capture; the source operand arrives one cycle after exec.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld_p2  <= 1'b0;
         r_init_p2 <= 1'b0;
         r_m2_p2   <= '0;
         r_d2_p2   <= '0;
      end else begin
         r_vld_p2  <= r_vld_p1;
         r_init_p2 <= r_init_p1;
         if (r_vld_p1) begin
            r_m2_p2 <= r_mat_rd_p1;
            r_d2_p2 <= exec_src_data;
         end
      end
   end

   // Product and extended sum; operands are extended before multiplying so the
   // low 2*DW bits equal the signed or unsigned product as required.
   always_comb begin
      w_m_ext    = {{DW{SGN & r_m2_p2[DW-1]}}, r_m2_p2};
      w_d_ext    = {{DW{SGN & r_d2_p2[DW-1]}}, r_d2_p2};
      w_prod     = w_m_ext * w_d_ext;
      w_prod_acc = {ACC_W{SGN & w_prod[2*DW-1]}};
      w_prod_acc[2*DW-1:0] = w_prod;
      w_sum      = {SGN & r_acc_left[ACC_W-1], r_acc_left}
                 + {SGN & w_prod_acc[ACC_W-1], w_prod_acc};
      w_sum_ovf  = SGN ? (w_sum[ACC_W] ^ w_sum[ACC_W-1]) : w_sum[ACC_W];
      w_acc_new  = (SAT != 0) ? f_saturate(w_sum) : f_wrap(w_sum);
   end

   // Stage p3: accumulate; a delayed init wins over a coincident product.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc_left <= '0;
         r_ovf      <= 1'b0;
      end else if (r_init_p2) begin
         r_acc_left <= '0;
         r_ovf      <= 1'b0;
      end else if (r_vld_p2) begin
         r_acc_left <= w_acc_new;
         r_ovf      <= r_ovf | w_sum_ovf;
      end
   end

   // Output chain register: shifts in the downstream core's result.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc_right <= '0;
      end else if (out_period) begin
         r_acc_right <= acc_next;
      end
   end

   assign acc  = update ? r_acc_left : r_acc_right;
   assign ovf  = r_ovf;
   assign busy = (!rst && (exec || init)) || r_vld_p1 || r_init_p1 || r_vld_p2 || r_init_p2;

endmodule

// File: tb/tb_mac_core_p.sv
// Testbench for mac_core_p: eight chained default cores plus one saturating
// core, checked against a cycle-schedule reference model.
module tb_mac_core_p;

   localparam int DW = 16, AW = 7, LW = 2, ACC_W = 32, NC = 8, MAXC = 48;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst, init, mat_v, exec, out_period, update;
   logic [AW-1:0]    mat_a, exec_mat_addr;
   logic [LW*DW-1:0] mat_d;
   logic [DW-1:0]    src [NC];
   logic [ACC_W-1:0] chain_in;
   logic [ACC_W-1:0] zero_acc;
   logic [ACC_W-1:0] acc_c [NC+1];
   logic             busy_c [NC];
   logic             ovf_c [NC];
   logic [ACC_W-1:0] acc_s;
   logic             busy_s, ovf_s;

   int checks = 0;
   int failures = 0;

   assign acc_c[NC] = chain_in;
   assign zero_acc  = '0;

   generate
      for (genvar g = 0; g < NC; g++) begin : g_core
         mac_core_p #(.DW(DW), .AW(AW), .LW(LW), .ACC_W(ACC_W), .SIGNED(1), .SAT(0)) u_core (
            .clk(clk), .rst(rst), .init(init), .mat_v(mat_v), .mat_a(mat_a), .mat_d(mat_d),
            .exec(exec), .exec_mat_addr(exec_mat_addr), .exec_src_data(src[g]),
            .out_period(out_period), .update(update), .acc_next(acc_c[g+1]),
            .acc(acc_c[g]), .busy(busy_c[g]), .ovf(ovf_c[g]));
      end
   endgenerate

   mac_core_p #(.DW(DW), .AW(AW), .LW(LW), .ACC_W(ACC_W), .SIGNED(1), .SAT(1)) u_sat (
      .clk(clk), .rst(rst), .init(init), .mat_v(mat_v), .mat_a(mat_a), .mat_d(mat_d),
      .exec(exec), .exec_mat_addr(exec_mat_addr), .exec_src_data(src[0]),
      .out_period(out_period), .update(update), .acc_next(zero_acc),
      .acc(acc_s), .busy(busy_s), .ovf(ovf_s));

   // schedule (per cycle inputs), observations and model expectations
   logic             s_rst [MAXC], s_init [MAXC], s_exec [MAXC], s_matv [MAXC];
   logic [AW-1:0]    s_addr [MAXC], s_mata [MAXC];
   logic [LW*DW-1:0] s_matd [MAXC];
   logic [DW-1:0]    s_src [MAXC];
   logic [ACC_W-1:0] o_acc [MAXC], o_sat [MAXC], e_acc [MAXC], e_sat [MAXC];
   logic             o_busy [MAXC], o_ovf [MAXC], o_ovfs [MAXC], o_busys [MAXC];
   logic             e_busy [MAXC], e_ovf [MAXC], e_ovfs [MAXC];

   // reference state
   logic [DW-1:0]    mm [1 << AW];
   logic [ACC_W-1:0] m_acc, m_sat;
   logic             m_ovf, m_ovfs;

   task automatic drive_idle();
      rst = 1'b0; init = 1'b0; mat_v = 1'b0; exec = 1'b0;
      out_period = 1'b0; update = 1'b1;
      mat_a = '0; mat_d = '0; exec_mat_addr = '0;
      for (int i = 0; i < NC; i++) src[i] = '0;
   endtask

   task automatic clear_sched();
      for (int c = 0; c < MAXC; c++) begin
         s_rst[c] = 0; s_init[c] = 0; s_exec[c] = 0; s_matv[c] = 0;
         s_addr[c] = '0; s_mata[c] = '0; s_matd[c] = '0; s_src[c] = '0;
      end
   endtask

   task automatic model_mac(input logic [DW-1:0] m, input logic [DW-1:0] s);
      longint p, w, t;
      longint maxv, minv;
      maxv = 64'sd2147483647;
      minv = -64'sd2147483648;
      p = longint'($signed(m)) * longint'($signed(s));
      w = longint'($signed(m_acc)) + p;
      if (w > maxv || w < minv) m_ovf = 1'b1;
      m_acc = w[31:0];
      t = longint'($signed(m_sat)) + p;
      if (t > maxv) begin
         m_sat = 32'h7FFF_FFFF; m_ovfs = 1'b1;
      end else if (t < minv) begin
         m_sat = 32'h8000_0000; m_ovfs = 1'b1;
      end else begin
         m_sat = t[31:0];
      end
   endtask

   // An op issued in cycle c reads the RAM as it was before cycle c's write,
   // takes its source in c+1, and lands on the edge ending c+2 unless rst hit
   // any of c..c+2. A reset clears everything on its edge.
   task automatic model_sched(input int n);
      logic [DW-1:0] rd [MAXC];
      for (int c = 0; c < n; c++) begin
         logic b;
         e_acc[c] = m_acc; e_sat[c] = m_sat; e_ovf[c] = m_ovf; e_ovfs[c] = m_ovfs;
         b = !s_rst[c] && (s_exec[c] || s_init[c]);
         if (c >= 1 && !s_rst[c-1] && (s_exec[c-1] || s_init[c-1])) b = 1'b1;
         if (c >= 2 && !s_rst[c-2] && !s_rst[c-1] && (s_exec[c-2] || s_init[c-2])) b = 1'b1;
         e_busy[c] = b;
         rd[c] = mm[s_addr[c]];
         if (s_rst[c]) begin
            m_acc = '0; m_sat = '0; m_ovf = 1'b0; m_ovfs = 1'b0;
         end else begin
            if (c >= 2 && !s_rst[c-2] && !s_rst[c-1]) begin
               if (s_init[c-2]) begin
                  m_acc = '0; m_sat = '0; m_ovf = 1'b0; m_ovfs = 1'b0;
               end else if (s_exec[c-2]) begin
                  model_mac(rd[c-2], s_src[c-1]);
               end
            end
            if (s_matv[c]) begin
               for (int k = 0; k < LW; k++)
                  mm[(int'(s_mata[c]) + k) % (1 << AW)] = s_matd[c][k*DW +: DW];
            end
         end
      end
   endtask

   task automatic run_sched(input int n);
      model_sched(n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         rst = s_rst[c]; init = s_init[c]; exec = s_exec[c]; exec_mat_addr = s_addr[c];
         mat_v = s_matv[c]; mat_a = s_mata[c]; mat_d = s_matd[c];
         for (int i = 0; i < NC; i++) src[i] = s_src[c];
         update = 1'b1; out_period = 1'b0;
         #1;
         o_acc[c] = acc_c[0]; o_busy[c] = busy_c[0]; o_ovf[c] = ovf_c[0];
         o_sat[c] = acc_s; o_ovfs[c] = ovf_s; o_busys[c] = busy_s;
      end
      drive_idle();
   endtask

   task automatic test_reset();
      drive_idle();
      rst = 1'b1; exec = 1'b1; init = 1'b1; update = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (busy_c[0] !== 1'b0 || busy_s !== 1'b0) begin
         failures++; $display("FAIL reset_busy_in_rst got=%b/%b exp=0/0", busy_c[0], busy_s);
      end
      rst = 1'b0; exec = 1'b0; init = 1'b0;
      #1;
      checks++;
      if (acc_c[0] !== 32'd0 || ovf_c[0] !== 1'b0 || busy_c[0] !== 1'b0) begin
         failures++; $display("FAIL reset_right acc=%h ovf=%b busy=%b exp 0/0/0", acc_c[0], ovf_c[0], busy_c[0]);
      end
      update = 1'b1;
      #1;
      checks++;
      if (acc_c[0] !== 32'd0 || acc_s !== 32'd0 || ovf_s !== 1'b0) begin
         failures++; $display("FAIL reset_left acc=%h sat=%h ovfs=%b exp 0/0/0", acc_c[0], acc_s, ovf_s);
      end
      m_acc = '0; m_sat = '0; m_ovf = 1'b0; m_ovfs = 1'b0;
   endtask

   task automatic init_memory();
      for (int b = 0; b < (1 << AW) / LW; b++) begin
         @(negedge clk);
         mat_v = 1'b1; mat_a = AW'(b * LW); mat_d = $urandom;
         for (int k = 0; k < LW; k++) mm[b * LW + k] = mat_d[k*DW +: DW];
      end
      @(negedge clk);
      drive_idle();
   endtask

   task automatic test_load_mac();
      clear_sched();
      s_matv[0] = 1; s_mata[0] = 7'd0; s_matd[0] = {16'd5, 16'd3};
      s_init[1] = 1;
      s_exec[2] = 1; s_addr[2] = 7'd0;
      s_exec[3] = 1; s_addr[3] = 7'd1; s_src[3] = 16'd4;
      s_src[4] = 16'hFFFE;
      run_sched(10);
      for (int c = 0; c < 10; c++) begin
         checks++;
         if ({o_acc[c], o_busy[c], o_ovf[c], o_sat[c], o_ovfs[c], o_busys[c]} !==
             {e_acc[c], e_busy[c], e_ovf[c], e_sat[c], e_ovfs[c], e_busy[c]}) begin
            failures++; $display("FAIL load_mac cyc=%0d acc=%h busy=%b ovf=%b exp acc=%h busy=%b ovf=%b",
                                 c, o_acc[c], o_busy[c], o_ovf[c], e_acc[c], e_busy[c], e_ovf[c]);
         end
      end
      checks++;
      if (o_acc[6] !== 32'd2 || o_busy[6] !== 1'b0) begin
         failures++; $display("FAIL load_mac_result acc=%h busy=%b exp 2/0", o_acc[6], o_busy[6]);
      end
   endtask

   task automatic test_wrap();
      clear_sched();
      s_matv[0] = 1; s_mata[0] = 7'd127; s_matd[0] = {16'hFFFE, 16'd7};
      s_init[1] = 1;
      s_exec[2] = 1; s_addr[2] = 7'd127;
      s_exec[3] = 1; s_addr[3] = 7'd0; s_src[3] = 16'd5;
      s_src[4] = 16'd3;
      s_matv[5] = 1; s_mata[5] = 7'd127; s_matd[5] = {16'd0, 16'd100};
      s_exec[5] = 1; s_addr[5] = 7'd127;
      s_src[6] = 16'd1;
      s_exec[7] = 1; s_addr[7] = 7'd127;
      s_src[8] = 16'd1;
      run_sched(13);
      for (int c = 0; c < 13; c++) begin
         checks++;
         if ({o_acc[c], o_busy[c], o_ovf[c], o_sat[c], o_ovfs[c], o_busys[c]} !==
             {e_acc[c], e_busy[c], e_ovf[c], e_sat[c], e_ovfs[c], e_busy[c]}) begin
            failures++; $display("FAIL wrap cyc=%0d acc=%h busy=%b exp acc=%h busy=%b",
                                 c, o_acc[c], o_busy[c], e_acc[c], e_busy[c]);
         end
      end
      checks++;
      if (o_acc[5] !== 32'd35 || o_acc[6] !== 32'd29 || o_acc[8] !== 32'd36 || o_acc[10] !== 32'd136) begin
         failures++; $display("FAIL wrap_values got=%0d,%0d,%0d,%0d exp=35,29,36,136",
                              o_acc[5], o_acc[6], o_acc[8], o_acc[10]);
      end
   endtask

   task automatic test_saturation();
      clear_sched();
      s_matv[0] = 1; s_mata[0] = 7'd10; s_matd[0] = {16'd4, 16'h7FFF};
      s_init[1] = 1;
      s_exec[2] = 1; s_addr[2] = 7'd10;
      s_exec[3] = 1; s_addr[3] = 7'd10; s_src[3] = 16'h7FFF;
      s_exec[4] = 1; s_addr[4] = 7'd11; s_src[4] = 16'h7FFF;
      s_src[5] = 16'h7FFF;
      s_exec[6] = 1; s_addr[6] = 7'd10;
      s_src[7] = 16'h7FFF;
      run_sched(12);
      for (int c = 0; c < 12; c++) begin
         checks++;
         if ({o_acc[c], o_ovf[c], o_sat[c], o_ovfs[c]} !== {e_acc[c], e_ovf[c], e_sat[c], e_ovfs[c]}) begin
            failures++; $display("FAIL sat cyc=%0d acc=%h ovf=%b sat=%h ovfs=%b exp %h %b %h %b",
                                 c, o_acc[c], o_ovf[c], o_sat[c], o_ovfs[c], e_acc[c], e_ovf[c], e_sat[c], e_ovfs[c]);
         end
      end
      checks++;
      if (o_sat[7] !== 32'h7FFF_FFFE || o_ovfs[7] !== 1'b0 || o_ovf[7] !== 1'b0) begin
         failures++; $display("FAIL sat_preload sat=%h ovfs=%b ovf=%b exp 7ffffffe/0/0", o_sat[7], o_ovfs[7], o_ovf[7]);
      end
      checks++;
      if (o_sat[9] !== 32'h7FFF_FFFF || o_ovfs[9] !== 1'b1) begin
         failures++; $display("FAIL sat_clamp sat=%h ovfs=%b exp 7fffffff/1", o_sat[9], o_ovfs[9]);
      end
      checks++;
      if (o_acc[9] !== 32'hBFFE_FFFF || o_ovf[9] !== 1'b1) begin
         failures++; $display("FAIL sat_wrap acc=%h ovf=%b exp bffeffff/1", o_acc[9], o_ovf[9]);
      end
   endtask

   task automatic test_init_collision();
      clear_sched();
      s_init[0] = 1; s_exec[0] = 1; s_addr[0] = 7'd10;
      s_exec[1] = 1; s_addr[1] = 7'd11; s_src[1] = 16'd100;
      s_src[2] = 16'd3;
      run_sched(8);
      for (int c = 0; c < 8; c++) begin
         checks++;
         if ({o_acc[c], o_busy[c], o_ovf[c], o_sat[c], o_ovfs[c]} !== {e_acc[c], e_busy[c], e_ovf[c], e_sat[c], e_ovfs[c]}) begin
            failures++; $display("FAIL collide cyc=%0d acc=%h ovf=%b exp acc=%h ovf=%b",
                                 c, o_acc[c], o_ovf[c], e_acc[c], e_ovf[c]);
         end
      end
      checks++;
      if (o_acc[3] !== 32'd0 || o_ovf[3] !== 1'b0 || o_acc[4] !== 32'd12 || o_sat[4] !== 32'd12) begin
         failures++; $display("FAIL collide_values acc3=%h ovf3=%b acc4=%h sat4=%h exp 0/0/c/c",
                              o_acc[3], o_ovf[3], o_acc[4], o_sat[4]);
      end
   endtask

   task automatic test_back_to_back();
      clear_sched();
      for (int c = 0; c < 40; c++) begin
         s_rst[c]  = ($urandom_range(0, 31) == 0);
         s_exec[c] = ($urandom_range(0, 9) < 8);
         s_init[c] = ($urandom_range(0, 9) == 0);
         s_matv[c] = ($urandom_range(0, 3) == 0);
         s_addr[c] = AW'($urandom);
         s_mata[c] = AW'($urandom);
         s_matd[c] = $urandom;
         s_src[c]  = DW'($urandom);
      end
      run_sched(44);
      for (int c = 0; c < 44; c++) begin
         checks++;
         if ({o_acc[c], o_busy[c], o_ovf[c], o_sat[c], o_ovfs[c], o_busys[c]} !==
             {e_acc[c], e_busy[c], e_ovf[c], e_sat[c], e_ovfs[c], e_busy[c]}) begin
            failures++; $display("FAIL b2b cyc=%0d acc=%h busy=%b ovf=%b sat=%h ovfs=%b exp %h %b %b %h %b",
                                 c, o_acc[c], o_busy[c], o_ovf[c], o_sat[c], o_ovfs[c],
                                 e_acc[c], e_busy[c], e_ovf[c], e_sat[c], e_ovfs[c]);
         end
      end
   endtask

   task automatic test_reset_mid();
      clear_sched();
      s_matv[0] = 1; s_mata[0] = 7'd30; s_matd[0] = {16'd9, 16'd6}; s_init[0] = 1;
      s_exec[1] = 1; s_addr[1] = 7'd30;
      s_src[2] = 16'd2;
      s_exec[5] = 1; s_addr[5] = 7'd31;
      s_rst[6] = 1; s_src[6] = 16'd5;
      run_sched(12);
      for (int c = 0; c < 12; c++) begin
         checks++;
         if ({o_acc[c], o_busy[c], o_ovf[c], o_sat[c]} !== {e_acc[c], e_busy[c], e_ovf[c], e_sat[c]}) begin
            failures++; $display("FAIL rst_mid cyc=%0d acc=%h busy=%b exp acc=%h busy=%b",
                                 c, o_acc[c], o_busy[c], e_acc[c], e_busy[c]);
         end
      end
      checks++;
      if (o_acc[6] !== 32'd12 || o_busy[6] !== 1'b1 || o_acc[7] !== 32'd0 || o_busy[7] !== 1'b0 ||
          o_acc[8] !== 32'd0 || o_acc[9] !== 32'd0) begin
         failures++; $display("FAIL rst_mid_values acc=%h,%h,%h,%h busy=%b,%b exp c,0,0,0 busy 1,0",
                              o_acc[6], o_acc[7], o_acc[8], o_acc[9], o_busy[6], o_busy[7]);
      end
   endtask

   task automatic test_chain();
      logic [ACC_W-1:0] exp_v;
      drive_idle();
      chain_in = 32'hCAFE_0001;
      @(negedge clk);
      mat_v = 1'b1; mat_a = 7'd20; mat_d = {16'd0, 16'd3}; init = 1'b1;
      mm[20] = 16'd3; mm[21] = 16'd0;
      @(negedge clk);
      mat_v = 1'b0; init = 1'b0; exec = 1'b1; exec_mat_addr = 7'd20;
      @(negedge clk);
      exec = 1'b0;
      for (int i = 0; i < NC; i++) src[i] = DW'(10 * i + 1);
      repeat (4) begin
         @(negedge clk);
         for (int i = 0; i < NC; i++) src[i] = '0;
      end
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         update = (j == 0); out_period = (j < NC);
         #1;
         exp_v = (j < NC) ? ACC_W'(3 * (10 * j + 1)) : chain_in;
         checks++;
         if (acc_c[0] !== exp_v) begin
            failures++; $display("FAIL chain slot=%0d got=%h exp=%h", j, acc_c[0], exp_v);
         end
      end
      for (int i = 0; i < NC; i++) begin
         checks++;
         if (busy_c[i] !== 1'b0 || ovf_c[i] !== 1'b0) begin
            failures++; $display("FAIL chain_idle core=%0d busy=%b ovf=%b exp 0/0", i, busy_c[i], ovf_c[i]);
         end
      end
      drive_idle();
   endtask

   initial begin
      chain_in = '0;
      drive_idle();
      test_reset();
      init_memory();
      test_load_mac();
      test_wrap();
      test_saturation();
      test_init_collision();
      test_back_to_back();
      test_reset_mid();
      test_chain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mac_core_p.md
MAC_CORE_P -- requirements
Module: mac_core_p

Interface
Parameters:
REQ-001 SHALL provide parameter DW, default 16, operand width in bits.
REQ-002 SHALL provide parameter AW, default 7, matrix address width; depth = 2**AW words.
REQ-003 SHALL provide parameter LW, default 2, matrix words per load beat (1..4).
REQ-004 SHALL provide parameter ACC_W, default 32, accumulator width; ACC_W >= 2*DW is a legal-configuration requirement.
REQ-005 SHALL provide parameter SIGNED, default 1: 1 = two's-complement operands, 0 = unsigned.
REQ-006 SHALL provide parameter SAT, default 0: 0 = wrap-around accumulate, 1 = saturating accumulate.

Ports:
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 SHALL have port init, input, 1 bit: accumulator clear request, pipelined to align with exec.
REQ-010 SHALL have ports mat_v / mat_a / mat_d, inputs, 1 / AW / LW*DW bits: matrix load strobe, base address and packed words.
REQ-011 SHALL have ports exec / exec_mat_addr, inputs, 1 / AW bits: MAC issue strobe and matrix read address.
REQ-012 SHALL have port exec_src_data, input, DW bits: source operand, sampled one cycle after its exec.
REQ-013 SHALL have ports out_period / update, inputs, 1 bit each: output-chain shift enable and result select.
REQ-014 SHALL have port acc_next, input, ACC_W bits: chain input from the downstream core.
REQ-015 SHALL have port acc, output, ACC_W bits: result/chain output.
REQ-016 SHALL have port busy, output, 1 bit: any MAC or init operation in flight.
REQ-017 SHALL have port ovf, output, 1 bit: sticky accumulate overflow flag.

Function
REQ-018 SHALL, on mat_v=1, write word k (mat_d[k*DW +: DW]) to address (mat_a+k) mod 2**AW for k=0..LW-1; address wrap-around is required behaviour.
REQ-019 SHALL register the matrix read on exec=1 at cycle t (mat_rd valid at t+1); a same-cycle write to the read address returns the old data.
REQ-020 SHALL capture operands m2=mat_rd and d2=exec_src_data at the edge ending cycle t+1.
REQ-021 SHALL update acc_left at the edge ending cycle t+2; the result is visible at t+3, i.e. 3-cycle latency, with back-to-back exec accepted every cycle.
REQ-022 SHALL form the product as a full 2*DW product (signed or unsigned per SIGNED), sign- or zero-extended to ACC_W before addition.
REQ-023 SHALL, with SAT=0, wrap the sum modulo 2**ACC_W; with SAT=1, clamp to the max/min representable value (unsigned: 2**ACC_W-1 / 0).
REQ-024 SHALL set ovf on any accumulate that overflows ACC_W, in either SAT mode; ovf holds until cleared.
REQ-025 SHALL delay init by 2 cycles; when the delayed init fires, acc_left and ovf go to 0.
REQ-026 SHALL give the delayed init priority over a coincident delayed exec, discarding that product.
REQ-027 SHALL load acc_right <= acc_next on out_period=1 and otherwise hold it.
REQ-028 SHALL drive acc = update ? acc_left : acc_right, combinationally.
REQ-029 SHALL drive busy=1 while any of the 2 exec or init pipeline stages holds a valid entry, and also in the cycle exec or init is asserted.
REQ-030 SHALL make mat_v and exec in the same cycle legal and independent of each other.

Reset
REQ-031 SHALL, on rst=1, clear acc_left, acc_right, ovf, m2, d2 and all pipeline valid bits at the next edge; acc reads 0 after it.
REQ-032 SHALL NOT reset matrix contents.
REQ-033 SHALL abort any in-flight exec/init on rst mid-operation; no accumulate occurs in the following cycles.
REQ-034 SHALL ignore all inputs in the cycle rst=1.

Verification
REQ-035 Load and MAC: LW=2, load [3,5] at address 0, init, exec addr0 with src=4 then addr1 with src=-2 -> acc_left=2 at t+3 of the second exec, with update=1.
REQ-036 Wrap and address: load at mat_a=127 -> words land at 127 and 0; exec reads of 127 and 0 return them.
REQ-037 Saturation: SAT=1, SIGNED=1, preload acc_left near 0x7FFFFFF0, MAC 0x7FFF*0x7FFF -> acc=0x7FFFFFFF and ovf=1; the same stimulus with SAT=0 wraps and ovf=1.
REQ-038 Init/exec collision: init and exec asserted in the same cycle -> acc_left=0 and the product is discarded; an exec one cycle later accumulates normally.
REQ-039 Chain shift: 8 chained instances, update pulse then out_period held 8 cycles -> acc of core 0 presents core results in order, one per cycle.
REQ-040 Reset mid-pipeline: rst the cycle after exec -> no acc change, busy=0, acc=0 after the reset edge.
